// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch stage sequencer: PC register, next-PC select, imem req/ready handshake
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN (reject pc loads with next_pc[1:0] != 0).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   branch_taken         B-type redirect request
//   jump                 J-type redirect request
//   jump_reg             R-type (register) redirect request
//   stall                downstream cannot accept a new instruction
//   next_pc[31:0]        next-PC value from the fetch datapath mux
//   imem_ready           instruction memory data valid for the current request
//   pc[31:0]             current fetch address
//   pc_sel[1:0]          mux select: 00 PC+4, 01 branch, 10 jump-register, 11 jump
//   imem_req             fetch request to instruction memory
//   instr_valid          instruction on the memory read port is valid this cycle
//   fetch_err            sticky error flag (timeout or misaligned load)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        stall,
  input  logic [31:0] next_pc,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [1:0]  pc_sel,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    HOLD  = 2'b10,
    ERR   = 2'b11
  } state_t;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  sel_q;
  logic        req_q;
  logic        err_q;
  logic [1:0]  sel_now;
  logic        misaligned;

  // Redirect priority: jump_reg > jump > branch_taken > sequential.
  always_comb begin
    sel_now = 2'b00;
    if (jump_reg)          sel_now = 2'b10;
    else if (jump)         sel_now = 2'b11;
    else if (branch_taken) sel_now = 2'b01;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      wait_cnt <= 8'd0;
      sel_q    <= 2'b00;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            if (!stall) begin
              if (misaligned) begin
                state <= ERR;
                req_q <= 1'b0;
                err_q <= 1'b1;
              end else begin
                pc       <= next_pc;
                wait_cnt <= 8'd0;
              end
            end else begin
              // Freeze the select chosen at acceptance; redirects are ignored in HOLD.
              sel_q <= sel_now;
              state <= HOLD;
              req_q <= 1'b0;
            end
          end else if (wait_cnt == MAX_WAIT_C) begin
            state <= ERR;
            req_q <= 1'b0;
            err_q <= 1'b1;
          end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (!stall) begin
            if (misaligned) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              pc       <= next_pc;
              wait_cnt <= 8'd0;
              state    <= FETCH;
              req_q    <= 1'b1;
            end
          end
        end
        ERR: begin
          // Sticky until reset; pc stays frozen.
          state <= ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign imem_req    = req_q;
  assign fetch_err   = err_q;
  assign instr_valid = (state == FETCH) && imem_ready;
  assign pc_sel      = (state == FETCH) ? sel_now :
                       (state == HOLD)  ? sel_q   : 2'b00;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

  localparam logic [31:0] RPC  = 32'h0000_0040;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc;
  logic [1:0]  pc_sel;
  logic        imem_req;
  logic        instr_valid;
  logic        fetch_err;

  int n_vec = 0;
  int n_bad = 0;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  fetch_ctrl #(.RESET_PC(RPC), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .jump(jump),
    .jump_reg(jump_reg), .stall(stall), .next_pc(next_pc), .imem_ready(imem_ready),
    .pc(pc), .pc_sel(pc_sel), .imem_req(imem_req), .instr_valid(instr_valid),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: "phase" is what the fetch stage is doing right now.
  localparam int P_START = 0, P_REQ = 1, P_HELD = 2, P_DEAD = 3;
  int          m_phase;
  logic [31:0] m_pc;
  int          m_waited;
  logic [1:0]  m_held_sel;

  function automatic logic [1:0] want_sel();
    if (jump_reg) return 2'd2;
    if (jump) return 2'd3;
    if (branch_taken) return 2'd1;
    return 2'd0;
  endfunction

  function automatic void model_reset();
    m_phase = P_START; m_pc = RPC; m_waited = 0; m_held_sel = 2'd0;
  endfunction

  function automatic void model_load();
    if (ALIGN_EN && next_pc[1:0] != 2'b00) m_phase = P_DEAD;
    else begin m_pc = next_pc; m_waited = 0; m_phase = P_REQ; end
  endfunction

  function automatic void model_edge();
    case (m_phase)
      P_START: m_phase = P_REQ;
      P_REQ:
        if (imem_ready) begin
          if (!stall) model_load();
          else begin m_held_sel = want_sel(); m_phase = P_HELD; end
        end else if (m_waited == MAXW) m_phase = P_DEAD;
        else m_waited++;
      P_HELD: if (!stall) model_load();
      default: ;
    endcase
  endfunction

  // Checks outputs against the model at mid-cycle, then advances one clock.
  task automatic cycle(input string tag);
    logic [1:0] esel;
    #3;
    esel = (m_phase == P_REQ) ? want_sel() : (m_phase == P_HELD) ? m_held_sel : 2'd0;
    n_vec++;
    if (pc !== m_pc) begin n_bad++; $display("FAIL %s pc got=%h exp=%h", tag, pc, m_pc); end
    n_vec++;
    if (imem_req !== (m_phase == P_REQ)) begin
      n_bad++; $display("FAIL %s imem_req got=%b exp=%b", tag, imem_req, m_phase == P_REQ);
    end
    n_vec++;
    if (instr_valid !== (m_phase == P_REQ && imem_ready)) begin
      n_bad++; $display("FAIL %s instr_valid got=%b exp=%b", tag, instr_valid, m_phase == P_REQ && imem_ready);
    end
    n_vec++;
    if (pc_sel !== esel) begin n_bad++; $display("FAIL %s pc_sel got=%b exp=%b", tag, pc_sel, esel); end
    n_vec++;
    if (fetch_err !== (m_phase == P_DEAD)) begin
      n_bad++; $display("FAIL %s fetch_err got=%b exp=%b", tag, fetch_err, m_phase == P_DEAD);
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    branch_taken = 0; jump = 0; jump_reg = 0; stall = 0; imem_ready = 0; next_pc = 32'h0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 0;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (pc !== RPC || imem_req !== 0 || instr_valid !== 0 || pc_sel !== 2'b00 || fetch_err !== 0) begin
      n_bad++; $display("FAIL reset_values pc=%h req=%b val=%b sel=%b err=%b exp pc=%h zeros",
                        pc, imem_req, instr_valid, pc_sel, fetch_err, RPC);
    end
    cycle("reset_idle");
  endtask

  task automatic test_sequential();
    logic [31:0] seen [3];
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      next_pc = m_pc + 32'd4;
      #3 seen[i] = pc;
      #(-0) ;
      cycle("seq");
    end
    n_vec++;
    if (seen[0] !== 32'h40 || seen[1] !== 32'h44 || seen[2] !== 32'h48) begin
      n_bad++; $display("FAIL seq_pcs got=%h,%h,%h exp=40,44,48", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_priority();
    imem_ready = 1; stall = 0;
    jump_reg = 1; jump = 1; branch_taken = 1; next_pc = 32'h0000_1000;
    cycle("prio_all");
    n_vec++;
    if (pc !== 32'h0000_1000) begin n_bad++; $display("FAIL prio_load got=%h exp=00001000", pc); end
    for (int i = 0; i < 12; i++) begin
      {jump_reg, jump, branch_taken} = 3'($urandom_range(0, 7));
      next_pc = {$urandom_range(0, 32'h3FFF), 2'b00};
      cycle("prio_rand");
    end
    clear_inputs();
  endtask

  task automatic test_stall_hold();
    imem_ready = 1; branch_taken = 1; stall = 1; next_pc = 32'h0000_2000;
    cycle("stall_accept");
    branch_taken = 0; jump = 1;
    for (int i = 0; i < 3; i++) cycle("stall_hold");
    n_vec++;
    if (pc_sel !== 2'b01 || imem_req !== 0) begin
      n_bad++; $display("FAIL hold_sel got sel=%b req=%b exp sel=01 req=0", pc_sel, imem_req);
    end
    jump = 0; stall = 0; next_pc = 32'h0000_3000;
    cycle("stall_release");
    n_vec++;
    if (pc !== 32'h0000_3000) begin n_bad++; $display("FAIL hold_release got=%h exp=00003000", pc); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int reqs = 0;
    apply_reset();
    cycle("to_idle");
    imem_ready = 0; stall = 1;
    for (int i = 0; i < MAXW + 4; i++) begin
      #2 if (imem_req === 1'b1) reqs++;
      #(-0) ;
      cycle("to_wait");
    end
    n_vec++;
    if (reqs != MAXW + 1) begin n_bad++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", reqs, MAXW + 1); end
    n_vec++;
    if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got=%b exp=1", fetch_err); end
    imem_ready = 1; stall = 0;
    cycle("to_sticky");
    rst_n = 0; model_reset();
    #1;
    n_vec++;
    if (fetch_err !== 0 || pc !== RPC || imem_req !== 0) begin
      n_bad++; $display("FAIL timeout_reset err=%b pc=%h req=%b exp 0,%h,0", fetch_err, pc, imem_req, RPC);
    end
    @(posedge clk); #1; rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_async_reset_mid_wait();
    cycle("mw_idle");
    imem_ready = 1; next_pc = 32'h0000_0500;
    cycle("mw_load");
    imem_ready = 0;
    cycle("mw_w0");
    cycle("mw_w1");
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (pc !== RPC || imem_req !== 0) begin
      n_bad++; $display("FAIL async_reset pc=%h req=%b exp %h,0", pc, imem_req, RPC);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_align();
    cycle("al_idle");
    imem_ready = 1; next_pc = 32'h0000_0102;
    cycle("al_load");
    n_vec++;
    if (ALIGN_EN) begin
      if (fetch_err !== 1 || pc !== RPC) begin
        n_bad++; $display("FAIL align_check err=%b pc=%h exp 1,%h", fetch_err, pc, RPC);
      end
    end else if (pc !== 32'h0000_0102) begin
      n_bad++; $display("FAIL align_pass pc=%h exp=00000102", pc);
    end
    apply_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      {jump_reg, jump, branch_taken} = 3'($urandom_range(0, 7));
      stall = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 9) > 2);
      next_pc = ($urandom_range(0, 19) == 0) ? $urandom : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if (m_phase == P_DEAD && $urandom_range(0, 3) == 0) apply_reset();
      cycle("random");
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_priority();
    test_stall_hold();
    test_timeout();
    test_async_reset_mid_wait();
    test_align();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the fetch stage: owns the PC register, drives the 2-bit next-PC mux select and runs a req/ready handshake with a multi-cycle instruction memory.
- Accepts redirect requests (branch, jump, jump-register) and stall from the decode/control path.
- Loads the next-PC value computed by the fetch datapath on each accepted fetch.
- Sits between the control unit and the fetch datapath (PC mux, PC+4 adder, instruction memory).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 15, consecutive un-acked request cycles before a fetch timeout; legal range 1..255, counter 8 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- branch_taken  in  1  B-type branch resolved taken (beq/bne/bgez/blez/bgtz).
- jump  in  1  J-type redirect (j/jal).
- jump_reg  in  1  R-type redirect (jr/jalr).
- stall  in  1  downstream cannot accept a new instruction.
- next_pc  in  32  next-PC value from the fetch datapath mux.
- imem_ready  in  1  instruction memory data valid for the current request.
- pc  out  32  current fetch address.
- pc_sel  out  2  mux select: 00 PC+4, 01 branch, 10 jump-register, 11 jump.
- imem_req  out  1  fetch request to instruction memory.
- instr_valid  out  1  instruction on the memory read port is valid this cycle.
- fetch_err  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, pc_sel=00, imem_req=0, instr_valid=0, fetch_err=0.
  - wait_cnt=0, sel_q=00, state=IDLE.
  - Takes effect immediately, including mid-WAIT or mid-HOLD.
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: imem_req=0. Moves to FETCH on the first clock edge after reset release.
- FETCH:
  - imem_req=1.
  - instr_valid = imem_ready (combinational, same cycle).
  - pc_sel is combinational from inputs with priority jump_reg > jump > branch_taken > PC+4.
  - On an edge with imem_ready=1 and stall=0: pc<=next_pc, wait_cnt<=0, stay in FETCH. Back-to-back single-cycle fetches sustain 1 instruction/cycle.
  - On an edge with imem_ready=1 and stall=1: sel_q<=current pc_sel, pc unchanged, go to HOLD.
  - On an edge with imem_ready=0: wait_cnt<=wait_cnt+1. pc and imem_req must remain stable while waiting.
  - When wait_cnt==MAX_WAIT and imem_ready=0 at an edge, go to ERR.
- HOLD:
  - imem_req=0, instr_valid=0, pc_sel=sel_q. Redirect inputs are ignored, so the decision taken at acceptance is preserved.
  - When stall=0 at an edge: pc<=next_pc, wait_cnt<=0, go to FETCH.
- ERR: imem_req=0, instr_valid=0, fetch_err=1, pc frozen. Only reset exits ERR.
- Arithmetic: pc is loaded verbatim from next_pc, so wrap-around (0xFFFF_FFFC -> 0x0000_0000) comes from the datapath adder. wait_cnt saturates and never wraps.
- Simultaneous events:
  - Several redirect inputs high at once resolve by the priority above.
  - stall is sampled only at an accepted fetch (FETCH) or in HOLD; stall while the request is un-acked has no effect.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined: any pc load where next_pc[1:0]!=2'b00 goes to ERR instead, fetch_err=1, and pc keeps its old value.
- Undefined: no alignment check; next_pc is loaded unchanged.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, then imem_ready tied 1 and next_pc=pc+4 -> pc steps 0x40, 0x44, 0x48; instr_valid=1 each cycle; pc_sel=00.
- jump_reg=1 and jump=1 together with branch_taken=1 in an accepted cycle -> pc_sel=10; pc loads next_pc (e.g. 32'h0000_1000) on that edge.
- stall=1 on an accepted fetch with branch_taken=1, then branch_taken dropped and stall held 3 cycles -> HOLD, imem_req=0, pc_sel stays 01; release loads next_pc.
- imem_ready held 0 with MAX_WAIT=4 -> imem_req=1 for 5 cycles, then ERR, fetch_err=1 sticky; pulse rst_n low -> all outputs return to reset values.
- rst_n asserted mid-wait (wait_cnt=2) -> pc=RESET_PC and imem_req=0 immediately, without waiting for a clock edge.
- FETCH_ALIGN_CHECK_EN defined, next_pc=32'h0000_0102 accepted -> fetch_err=1 and pc unchanged; macro undefined -> pc=32'h0000_0102.
